fetch_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage pipelined CPU.
- Holds the program counter (PC) and drives the instruction-memory (GDM) address and enable.
- Selects the next PC from sequential, branch, register-jump, indexed-jump or exception-vector sources.
- Registers the fetched instruction and its next-PC value into the IF/ID pipeline register for Decode, with bubble insertion (Execute stall) and hold (Forwarding stall).

---
 rtl/fetch_stage.sv | 63 ++++++
 tb/tb_fetch_stage.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, instruction-memory
// request and the IF/ID pipeline register feeding Decode.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'd0,
  parameter logic [31:0] EXC_VECTOR = 32'd64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ex_if_stall,
  input  logic        fw_if_id_stall,
  input  logic        id_if_selfontepc,
  input  logic [1:0]  id_if_seltipopc,
  input  logic [31:0] id_if_rega,
  input  logic [31:0] id_if_pcimd2ext,
  input  logic [31:0] id_if_pcindx,
  output logic [31:0] if_id_proximopc,
  output logic [31:0] if_id_instrucao,
  output logic        if_gdm_en,
  output logic [31:0] if_gdm_addr,
  input  logic [31:0] gdm_if_data
);

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] npc;

  assign pc_plus4    = pc + 32'd4;
  assign if_gdm_addr = pc;

  // Next-PC selection: sequential unless Decode requests a redirect.
  always_comb begin
    npc = pc_plus4;
    if (id_if_selfontepc) begin
      unique case (id_if_seltipopc)
        2'b00:   npc = id_if_pcimd2ext;
        2'b01:   npc = id_if_rega;
        2'b10:   npc = id_if_pcindx;
        default: npc = EXC_VECTOR;
      endcase
    end
  end

  // PC, memory enable and IF/ID register; execute stall outranks forwarding stall.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc              <= RESET_PC;
      if_gdm_en       <= 1'b0;
      if_id_proximopc <= 32'd0;
      if_id_instrucao <= 32'd0;
    end else begin
      if_gdm_en <= 1'b1;
      if (ex_if_stall) begin
        if_id_instrucao <= 32'd0;
        if_id_proximopc <= pc;
      end else if (!fw_if_id_stall) begin
        if_id_instrucao <= gdm_if_data;
        if_id_proximopc <= pc_plus4;
        pc              <= npc;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reference model checked every falling edge
// plus literal expectations at key points of the sequence.
module tb_fetch_stage;

  logic        clock;
  logic        reset;
  logic        ex_if_stall;
  logic        fw_if_id_stall;
  logic        id_if_selfontepc;
  logic [1:0]  id_if_seltipopc;
  logic [31:0] id_if_rega;
  logic [31:0] id_if_pcimd2ext;
  logic [31:0] id_if_pcindx;
  logic [31:0] if_id_proximopc;
  logic [31:0] if_id_instrucao;
  logic        if_gdm_en;
  logic [31:0] if_gdm_addr;
  logic [31:0] gdm_if_data;

  int total = 0;
  int bad   = 0;

  fetch_stage dut (
    .clock           (clock),
    .reset           (reset),
    .ex_if_stall     (ex_if_stall),
    .fw_if_id_stall  (fw_if_id_stall),
    .id_if_selfontepc(id_if_selfontepc),
    .id_if_seltipopc (id_if_seltipopc),
    .id_if_rega      (id_if_rega),
    .id_if_pcimd2ext (id_if_pcimd2ext),
    .id_if_pcindx    (id_if_pcindx),
    .if_id_proximopc (if_id_proximopc),
    .if_id_instrucao (if_id_instrucao),
    .if_gdm_en       (if_gdm_en),
    .if_gdm_addr     (if_gdm_addr),
    .gdm_if_data     (gdm_if_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Instruction memory contents: never zero, address 0 holds 32'h0B.
  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a << 8) ^ 32'h0000_000B;
  endfunction

  assign gdm_if_data = instr_of(if_gdm_addr);

  // Reference model
  logic [31:0] m_pc, m_prox, m_instr;
  logic        m_en;
  logic [31:0] m_tgt [4];

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_pc = 32'd0; m_en = 1'b0; m_prox = 32'd0; m_instr = 32'd0;
    end else begin
      m_en = 1'b1;
      if (ex_if_stall) begin
        m_instr = 32'd0;
        m_prox  = m_pc;
      end else if (!fw_if_id_stall) begin
        m_tgt[0] = id_if_pcimd2ext;
        m_tgt[1] = id_if_rega;
        m_tgt[2] = id_if_pcindx;
        m_tgt[3] = 32'd64;
        m_instr  = instr_of(m_pc);
        m_prox   = m_pc + 32'd4;
        m_pc     = id_if_selfontepc ? m_tgt[id_if_seltipopc] : m_pc + 32'd4;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  bit cmp_on = 1'b0;

  // Every falling edge: DUT outputs must match the model.
  always @(negedge clock) begin
    if (cmp_on) begin
      chk("model_addr",  if_gdm_addr,     m_pc);
      chk("model_en",    {31'd0, if_gdm_en}, {31'd0, m_en});
      chk("model_prox",  if_id_proximopc, m_prox);
      chk("model_instr", if_id_instrucao, m_instr);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic redirect(input logic [1:0] sel, input logic [31:0] tgt);
    id_if_selfontepc = 1'b1;
    id_if_seltipopc  = sel;
    id_if_pcimd2ext  = (sel == 2'b00) ? tgt : 32'hDEAD_0000;
    id_if_rega       = (sel == 2'b01) ? tgt : 32'hDEAD_0004;
    id_if_pcindx     = (sel == 2'b10) ? tgt : 32'hDEAD_0008;
  endtask

  logic [31:0] hold_prox, hold_instr, hold_addr;

  initial begin
    reset = 1'b1;
    ex_if_stall = 1'b0; fw_if_id_stall = 1'b0;
    id_if_selfontepc = 1'b0; id_if_seltipopc = 2'b00;
    id_if_rega = '0; id_if_pcimd2ext = '0; id_if_pcindx = '0;
    #1 reset = 1'b0;
    #11;
    cmp_on = 1'b1;
    chk("rst_prox",  if_id_proximopc, 32'd0);
    chk("rst_instr", if_id_instrucao, 32'd0);
    chk("rst_en",    {31'd0, if_gdm_en}, 32'd0);
    chk("rst_addr",  if_gdm_addr, 32'd0);
    reset = 1'b1;

    tick();
    chk("first_en",    {31'd0, if_gdm_en}, 32'd1);
    chk("first_addr",  if_gdm_addr, 32'd4);
    chk("first_instr", if_id_instrucao, 32'h0B);
    chk("first_prox",  if_id_proximopc, 32'd4);

    tick(); chk("seq_addr8", if_gdm_addr, 32'd8);
    chk("seq_prox8", if_id_proximopc, 32'd8);
    tick(); chk("seq_addr12", if_gdm_addr, 32'd12);

    redirect(2'b00, if_gdm_addr + 32'd32);
    tick(); chk("redir_imd", if_gdm_addr, 32'd44);
    chk("redir_imd_prox", if_id_proximopc, 32'd16);
    redirect(2'b01, 32'd23);
    tick(); chk("redir_rega", if_gdm_addr, 32'd23);
    redirect(2'b10, 32'd46);
    tick(); chk("redir_indx", if_gdm_addr, 32'd46);
    redirect(2'b11, 32'd0);
    tick(); chk("redir_exc", if_gdm_addr, 32'd64);
    id_if_selfontepc = 1'b0;
    tick(); chk("after_exc", if_gdm_addr, 32'd68);

    // Execute stall with every redirect type presented
    ex_if_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      redirect(2'(i), 32'd200 + 32'(i));
      tick();
      chk("ex_addr",  if_gdm_addr, 32'd68);
      chk("ex_instr", if_id_instrucao, 32'd0);
      chk("ex_prox",  if_id_proximopc, 32'd68);
    end
    ex_if_stall = 1'b0;
    id_if_selfontepc = 1'b0;
    tick();
    chk("ex_resume_addr",  if_gdm_addr, 32'd72);
    chk("ex_resume_instr", if_id_instrucao, instr_of(32'd68));

    // Forwarding stall: everything holds
    hold_prox = if_id_proximopc; hold_instr = if_id_instrucao; hold_addr = if_gdm_addr;
    fw_if_id_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      redirect(2'(i), 32'd300 + 32'(i));
      tick();
      chk("fw_addr",  if_gdm_addr, hold_addr);
      chk("fw_instr", if_id_instrucao, hold_instr);
      chk("fw_prox",  if_id_proximopc, hold_prox);
    end
    chk("fw_addr_lit", hold_addr, 32'd72);
    fw_if_id_stall = 1'b0;
    id_if_selfontepc = 1'b0;
    tick();
    chk("fw_resume_addr", if_gdm_addr, 32'd76);
    chk("fw_resume_prox", if_id_proximopc, 32'd76);

    // Both stalls: execute stall wins
    ex_if_stall = 1'b1; fw_if_id_stall = 1'b1;
    tick();
    chk("both_instr", if_id_instrucao, 32'd0);
    chk("both_addr",  if_gdm_addr, 32'd76);
    chk("both_prox",  if_id_proximopc, 32'd76);
    ex_if_stall = 1'b0; fw_if_id_stall = 1'b0;
    tick(); tick();
    chk("pre_rst_addr", if_gdm_addr, 32'd84);

    // Asynchronous reset between edges
    #2 reset = 1'b0;
    #1;
    chk("async_addr",  if_gdm_addr, 32'd0);
    chk("async_en",    {31'd0, if_gdm_en}, 32'd0);
    chk("async_prox",  if_id_proximopc, 32'd0);
    chk("async_instr", if_id_instrucao, 32'd0);
    tick();
    chk("async_hold_addr", if_gdm_addr, 32'd0);
    reset = 1'b1;
    tick();
    chk("post_rst_addr", if_gdm_addr, 32'd4);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
